// File: rtl/keccak_pkg.sv
// Keccak-f[1600] round controller shared types and constants.
// Optional abort input is enabled with KECCAK_CTRL_ABORT_EN.
package keccak_pkg;

  localparam int KECCAK_NR     = 24;
  localparam int KECCAK_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } kc_state_e;

  function automatic bit ur_legal(input int ur, input int nr);
    return (ur inside {1, 2, 3, 4, 6, 8, 12}) && (nr % ur == 0);
  endfunction

endpackage

// File: rtl/keccak_round_cnt.sv
// Round counter stepping by UR, wrapping to 0 after the last group.
// Part of keccak_round_ctrl (abort via KECCAK_CTRL_ABORT_EN drives clr).
module keccak_round_cnt
  import keccak_pkg::*;
#(
  parameter int UR = 1,
  parameter int NR = KECCAK_NR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  output logic [KECCAK_ADDR_W-1:0] cnt,
  output logic                     last
);

  localparam logic [KECCAK_ADDR_W-1:0] STEP =
    KECCAK_ADDR_W'(UR);
  localparam logic [KECCAK_ADDR_W-1:0] LAST_V =
    KECCAK_ADDR_W'(NR - UR);

  logic [KECCAK_ADDR_W-1:0] cnt_q;
  logic [KECCAK_ADDR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST_V);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] sequencer: IDLE/LOAD/RUN/HOLD with UR rounds per cycle.
// Define KECCAK_CTRL_ABORT_EN to add the abort input.
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int UR = 1,
  parameter int NR = KECCAK_NR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  output logic [KECCAK_ADDR_W-1:0] addr,
  output logic                     load_en,
  output logic                     round_en,
  output logic                     last_round,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef KECCAK_CTRL_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  if (!ur_legal(UR, NR)) begin : g_bad_ur
    $error("keccak_round_ctrl: illegal UR/NR");
  end

  kc_state_e                state_q;
  kc_state_e                state_d;
  logic [KECCAK_ADDR_W-1:0] cnt;
  logic                     cnt_last;
  logic                     abort_w;
  logic                     kill;

`ifdef KECCAK_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign kill = abort_w &&
    (state_q == LOAD || state_q == RUN);

  keccak_round_cnt #(
    .UR(UR),
    .NR(NR)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (kill || state_q != RUN),
    .en   (state_q == RUN),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_valid) state_d = LOAD;
      LOAD: state_d = kill ? IDLE : RUN;
      RUN: begin
        if (kill)          state_d = IDLE;
        else if (cnt_last) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready)
          state_d = start_valid ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // start_ready in HOLD follows out_ready so handoff and restart coincide
  always_comb begin
    start_ready = 1'b0;
    addr        = '0;
    load_en     = 1'b0;
    round_en    = 1'b0;
    last_round  = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): start_ready = 1'b1;
      (state_q == LOAD): begin
        load_en = 1'b1;
        busy    = 1'b1;
      end
      (state_q == RUN): begin
        round_en   = 1'b1;
        addr       = cnt;
        last_round = cnt_last;
        busy       = 1'b1;
      end
      (state_q == HOLD): begin
        out_valid   = 1'b1;
        start_ready = out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl with UR=1 and UR=4 instances.
// Abort steps are built when KECCAK_CTRL_ABORT_EN is defined.
module tb_keccak_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sv1, or1, sr1, ld1, re1, lr1, bz1, ov1;
  logic [4:0] ad1;
  logic       sv4, or4, sr4, ld4, re4, lr4, bz4, ov4;
  logic [4:0] ad4;
  logic       ab1;

  int n_chk;
  int n_fail;

  keccak_round_ctrl #(.UR(1), .NR(24)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(sv1),
    .start_ready(sr1),
    .addr       (ad1),
    .load_en    (ld1),
    .round_en   (re1),
    .last_round (lr1),
    .busy       (bz1),
    .out_valid  (ov1),
    .out_ready  (or1)
`ifdef KECCAK_CTRL_ABORT_EN
    ,
    .abort      (ab1)
`endif
  );

  keccak_round_ctrl #(.UR(4), .NR(24)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(sv4),
    .start_ready(sr4),
    .addr       (ad4),
    .load_en    (ld4),
    .round_en   (re4),
    .last_round (lr4),
    .busy       (bz4),
    .out_valid  (ov4),
    .out_ready  (or4)
`ifdef KECCAK_CTRL_ABORT_EN
    ,
    .abort      (1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    int first_ld;
    int second_ld;
    int third_ld;
    int k;
    bit seen_ov;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    sv1 = 0; or1 = 0; sv4 = 0; or4 = 0; ab1 = 0;
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Reset values
    chk("rst_start_ready", 32'(sr1), 1);
    chk("rst_addr", 32'(ad1), 0);
    chk("rst_load_en", 32'(ld1), 0);
    chk("rst_round_en", 32'(re1), 0);
    chk("rst_last", 32'(lr1), 0);
    chk("rst_busy", 32'(bz1), 0);
    chk("rst_out_valid", 32'(ov1), 0);

    // UR=1 single permutation, with backpressure in HOLD
    sv1 = 1'b1;
    tick;
    sv1 = 1'b0;
    chk("u1_load_en", 32'(ld1), 1);
    chk("u1_load_busy", 32'(bz1), 1);
    chk("u1_load_sr", 32'(sr1), 0);
    chk("u1_load_addr", 32'(ad1), 0);
    for (int i = 0; i < 24; i++) begin
      tick;
      chk("u1_round_en", 32'(re1), 1);
      chk("u1_addr", 32'(ad1), 32'(i));
      chk("u1_last", 32'(lr1), (i == 23) ? 1 : 0);
      chk("u1_ov_early", 32'(ov1), 0);
    end
    tick;
    chk("u1_out_valid", 32'(ov1), 1);
    chk("u1_hold_round", 32'(re1), 0);
    chk("u1_hold_busy", 32'(bz1), 0);
    sv1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(ov1), 1);
      chk("bp_addr", 32'(ad1), 0);
      chk("bp_start_ready", 32'(sr1), 0);
      chk("bp_load_en", 32'(ld1), 0);
      tick;
    end
    sv1 = 1'b0;
    or1 = 1'b1;
    #1;
    chk("bp_release_sr", 32'(sr1), 1);
    tick;
    or1 = 1'b0;
    chk("bp_idle_ov", 32'(ov1), 0);
    chk("bp_idle_sr", 32'(sr1), 1);
    chk("bp_idle_busy", 32'(bz1), 0);

    // UR=4 single permutation
    sv4 = 1'b1;
    tick;
    sv4 = 1'b0;
    chk("u4_load_en", 32'(ld4), 1);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("u4_round_en", 32'(re4), 1);
      chk("u4_addr", 32'(ad4), 32'(4 * i));
      chk("u4_last", 32'(lr4), (i == 5) ? 1 : 0);
    end
    tick;
    chk("u4_out_valid", 32'(ov4), 1);
    or4 = 1'b1;
    tick;
    chk("u4_idle_ov", 32'(ov4), 0);

    // UR=4 back-to-back: loads expected 8 cycles apart
    first_ld = -1; second_ld = -1; third_ld = -1;
    sv4 = 1'b1;
    or4 = 1'b1;
    for (k = 1; k <= 20; k++) begin
      tick;
      if (k == 8) begin
        chk("b2b_hold_ov", 32'(ov4), 1);
        chk("b2b_hold_sr", 32'(sr4), 1);
      end
      if (ld4) begin
        if (first_ld < 0)       first_ld = k;
        else if (second_ld < 0) second_ld = k;
        else if (third_ld < 0)  third_ld = k;
      end
    end
    chk("b2b_first_load", 32'(first_ld), 1);
    chk("b2b_second_load", 32'(second_ld), 9);
    chk("b2b_third_load", 32'(third_ld), 17);
    sv4 = 1'b0;

    // Asynchronous reset mid-RUN at addr 11
    sv1 = 1'b1;
    tick;
    sv1 = 1'b0;
    k = 0;
    while (!(re1 && ad1 == 5'd11) && k < 40) begin
      tick;
      k++;
    end
    chk("mr_reach_addr11", 32'(ad1), 11);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bz1), 0);
    chk("mr_round_en", 32'(re1), 0);
    chk("mr_addr", 32'(ad1), 0);
    chk("mr_start_ready", 32'(sr1), 1);
    chk("mr_out_valid", 32'(ov1), 0);
    chk("mr_u4_busy", 32'(bz4), 0);
    tick;
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (ov1) seen_ov = 1'b1;
    end
    chk("mr_no_out_valid", 32'(seen_ov), 0);

`ifdef KECCAK_CTRL_ABORT_EN
    // Abort at addr 7, then a fresh full run
    sv1 = 1'b1;
    tick;
    sv1 = 1'b0;
    k = 0;
    while (!(re1 && ad1 == 5'd7) && k < 40) begin
      tick;
      k++;
    end
    chk("ab_reach_addr7", 32'(ad1), 7);
    ab1 = 1'b1;
    tick;
    ab1 = 1'b0;
    chk("ab_busy", 32'(bz1), 0);
    chk("ab_start_ready", 32'(sr1), 1);
    chk("ab_round_en", 32'(re1), 0);
    seen_ov = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ov1) seen_ov = 1'b1;
    end
    chk("ab_no_out_valid", 32'(seen_ov), 0);
    sv1 = 1'b1;
    ab1 = 1'b1;
    tick;
    sv1 = 1'b0;
    ab1 = 1'b0;
    chk("ab_restart_load", 32'(ld1), 1);
    for (int i = 0; i < 24; i++) begin
      tick;
      chk("ab_addr", 32'(ad1), 32'(i));
    end
    tick;
    chk("ab_out_valid", 32'(ov1), 1);
    or1 = 1'b1;
    tick;
    or1 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_round_ctrl.md
# keccak_round_ctrl

Sequencer for the Keccak-f[1600] permutation. It accepts a start request, steps a round counter by UR rounds per cycle, and drives the round-constant address into the constants ROM. It also issues load and round-enable strobes to the state datapath and holds a result-valid handshake until the downstream sponge logic consumes the permuted state. It sits directly upstream of the round-constant ROM and controls the same datapath that ROM feeds.

## Interface
Parameters:
- UR, 1, rounds applied per cycle; legal values 1, 2, 3, 4, 6, 8, 12 (must divide NR).
- NR, 24, total rounds per permutation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to permute the state currently presented to the datapath.
- start_ready  out  1  request accepted when start_valid && start_ready.
- addr  out  5  round-constant ROM address (first round of this cycle's group).
- load_en  out  1  datapath loads the input state.
- round_en  out  1  datapath applies UR rounds using the constants at addr..addr+UR-1.
- last_round  out  1  this round_en cycle is the final group.
- busy  out  1  high in LOAD or RUN.
- out_valid  out  1  permuted state is stable and available.
- out_ready  in  1  consumer accepts the result.
- abort  in  1  present only with KECCAK_CTRL_ABORT_EN.

## Operation
- FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - start_ready=1.
  - On start_valid, go to LOAD.
- LOAD:
  - load_en=1, addr=0.
  - Go to RUN.
- RUN:
  - round_en=1 and addr=cnt.
  - cnt advances by UR each cycle.
  - last_round=1 when cnt==NR-UR; the next state is HOLD and cnt clears to 0.
- HOLD:
  - out_valid=1 until out_ready.
  - start_ready=out_ready, so a result handoff and a new start can complete in the same cycle.
  - out_ready && start_valid: go to LOAD (back-to-back operation, no IDLE bubble).
  - out_ready && !start_valid: go to IDLE.
- Outputs are decoded from the registered state and cnt (Moore); there is no combinational path from start_valid to any output.
- Width rule: cnt is 5 bits; cnt+UR never exceeds NR-UR+UR=24, so no wrap is possible. addr is 0 outside RUN.
- start_valid in LOAD or RUN is ignored, because start_ready=0.
- out_ready outside HOLD has no effect.

## Timing
- Reset values: state=IDLE, cnt=0, addr=0, start_ready=1, all other outputs 0.
- Reset is asynchronous mid-operation: the FSM returns to IDLE immediately and no out_valid is produced.
- If the handshake completes in cycle t:
  - load_en is high in cycle t+1.
  - round_en is high in cycles t+2 .. t+1+NR/UR.
  - out_valid rises in cycle t+2+NR/UR.
- UR=1: 24 round cycles; out_valid at t+26.
- UR=4: 6 round cycles; out_valid at t+8.
- Back-to-back throughput is one permutation per NR/UR+2 cycles.

## Configuration
- KECCAK_CTRL_ABORT_EN defined:
  - Adds the abort input.
  - abort in LOAD or RUN: IDLE on the next edge, cnt=0, no out_valid.
  - abort in IDLE or HOLD: ignored.
  - If abort and start_valid are both high in IDLE, the start is accepted.
- KECCAK_CTRL_ABORT_EN undefined: the port is absent and behaviour is as above with abort tied to 0.

## Structure
- keccak_pkg holds:
  - KECCAK_NR=24 and KECCAK_ADDR_W=5.
  - The FSM state typedef (IDLE/LOAD/RUN/HOLD, 2 bits).
  - A UR legality check function.
- Sub-module keccak_round_cnt holds the modulo-NR counter with step UR. It has inputs clr and en, and outputs cnt and last.
- The FSM and output decode live in the top level.

## Test plan
- Reset then single start, UR=1:
  - start_valid pulse at t.
  - Expect load_en at t+1.
  - Expect round_en at t+2..t+25 with addr stepping 0,1,…,23.
  - Expect last_round only at addr=23.
  - Expect out_valid at t+26.
- UR=4:
  - addr sequence 0,4,8,12,16,20.
  - last_round at addr=20.
  - out_valid at t+8.
- Back-to-back:
  - Hold start_valid=1 and out_ready=1.
  - HOLD goes to LOAD in the same cycle as the handshake.
  - The second load_en comes exactly NR/UR+2 cycles after the first.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in HOLD.
  - out_valid stays 1 and addr stays 0.
  - start_ready stays 0 and start_valid is ignored.
- Reset mid-RUN: assert rst_n=0 at addr=11; all outputs return to reset values asynchronously.
- Abort with KECCAK_CTRL_ABORT_EN: abort at addr=7 gives IDLE next cycle and no out_valid; a new start then runs the full sequence from addr 0.
